// File: rtl/pipe_pkg.sv
// Shared types and encodings for the pipeline hazard/redirect controller.
package pipe_pkg;
    localparam int REG_W = 6;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_ALU = 2'b01;
    localparam logic [1:0] PC_MEM = 2'b10;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side signals of pipe_ctrl: decode/EX/WB status in, enables/flushes out.
interface pipe_ctrl_if;
    import pipe_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_valid;
    logic             ex_memToReg;
    logic             ex_RegWrt;
    logic [REG_W-1:0] ex_rd;
    logic             wb_BranchZ;
    logic             wb_BranchN;
    logic             wb_Jump;
    logic             wb_JumpMem;
    logic             wb_N;
    logic             wb_Z;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exwb_flush;
    logic [1:0]       pc_sel;
    logic [15:0]      stall_count;
    logic [15:0]      flush_count;

    modport slave (
        input  id_rs, id_rt, id_valid, ex_memToReg, ex_RegWrt, ex_rd,
        input  wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem, wb_N, wb_Z,
        output pc_en, ifid_en, ifid_flush, idex_flush, exwb_flush, pc_sel,
        output stall_count, flush_count
    );

    modport master (
        output id_rs, id_rt, id_valid, ex_memToReg, ex_RegWrt, ex_rd,
        output wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem, wb_N, wb_Z,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exwb_flush, pc_sel,
        input  stall_count, flush_count
    );
endinterface

// File: rtl/sat_cnt16.sv
// 16-bit event counter with synchronous clear that holds at all-ones.
module sat_cnt16 (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);
    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Load-use stall and taken-redirect flush controller for a short in-order pipeline.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        hazard;
    logic        taken;
    logic [1:0]  ev_inc;
    logic [15:0] ev_count [2];

    assign hazard = bus.id_valid & bus.ex_memToReg & bus.ex_RegWrt
                  & (bus.ex_rd != '0)
                  & ((bus.ex_rd == bus.id_rs) | (bus.ex_rd == bus.id_rt));
    assign taken  = bus.wb_Jump | bus.wb_JumpMem
                  | (bus.wb_BranchZ & bus.wb_Z) | (bus.wb_BranchN & bus.wb_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN, ST_STALL: begin
                // A redirect wins over the hazard and cuts any stall short.
                if (taken) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = 3'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end else if (state_q == ST_STALL) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = ST_RUN;
                end else if (hazard && (LOAD_STALL > 1)) begin
                    state_d = ST_STALL;
                    cnt_d   = 3'(LOAD_STALL - 1);
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1)
                    state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.pc_en      = 1'b1;
        bus.ifid_en    = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.exwb_flush = 1'b0;
        bus.pc_sel     = PC_SEQ;
        if (rst) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exwb_flush = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exwb_flush = 1'b1;
        end else if (taken) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            bus.exwb_flush = 1'b1;
            bus.pc_sel     = bus.wb_JumpMem ? PC_MEM : PC_ALU;
        end else if ((state_q == ST_STALL) || hazard) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
        end
    end

    // Stalls are counted once per hazard, on the cycle it is first seen in RUN.
    assign ev_inc[0] = !rst && (state_q == ST_RUN) && hazard && !taken;
    assign ev_inc[1] = !rst && (state_q != ST_FLUSH) && taken;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_cnt16 u_cnt (
            .clk   (clk),
            .clr   (rst),
            .en    (ev_inc[gi]),
            .count (ev_count[gi])
        );
    end

    assign bus.stall_count = ev_count[0];
    assign bus.flush_count = ev_count[1];
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a LOAD_STALL=3 instance.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [6:0] O_RUN   = 7'b11_000_00;
    localparam logic [6:0] O_STALL = 7'b00_010_00;
    localparam logic [6:0] O_ALU   = 7'b11_111_01;
    localparam logic [6:0] O_MEM   = 7'b11_111_10;
    localparam logic [6:0] O_FLUSH = 7'b11_111_00;
    localparam logic [6:0] O_RST   = 7'b00_111_00;

    pipe_ctrl_if pif ();
    pipe_ctrl_if pif3 ();

    pipe_ctrl u_dut (.clk(clk), .rst(rst), .bus(pif));
    pipe_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2)) u_dut3 (.clk(clk), .rst(rst), .bus(pif3));

    wire [6:0] o  = {pif.pc_en, pif.ifid_en, pif.ifid_flush, pif.idex_flush,
                     pif.exwb_flush, pif.pc_sel};
    wire [6:0] o3 = {pif3.pc_en, pif3.ifid_en, pif3.ifid_flush, pif3.idex_flush,
                     pif3.exwb_flush, pif3.pc_sel};

    always #5 clk = ~clk;

    task automatic clear_inputs();
        pif.id_rs = '0;  pif.id_rt = '0;  pif.id_valid = 0;
        pif.ex_memToReg = 0; pif.ex_RegWrt = 0; pif.ex_rd = '0;
        pif.wb_BranchZ = 0; pif.wb_BranchN = 0; pif.wb_Jump = 0;
        pif.wb_JumpMem = 0; pif.wb_N = 0; pif.wb_Z = 0;
        pif3.id_rs = '0; pif3.id_rt = '0; pif3.id_valid = 0;
        pif3.ex_memToReg = 0; pif3.ex_RegWrt = 0; pif3.ex_rd = '0;
        pif3.wb_BranchZ = 0; pif3.wb_BranchN = 0; pif3.wb_Jump = 0;
        pif3.wb_JumpMem = 0; pif3.wb_N = 0; pif3.wb_Z = 0;
    endtask

    task automatic hazard_main(input logic [5:0] rd, input logic [5:0] rs,
                               input logic [5:0] rt, input logic valid);
        pif.ex_memToReg = 1; pif.ex_RegWrt = 1; pif.ex_rd = rd;
        pif.id_rs = rs; pif.id_rt = rt; pif.id_valid = valid;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1; clear_inputs();
        @(negedge clk); rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        hazard_main(6'd5, 6'd5, 6'd0, 1'b1);
        pif.wb_JumpMem = 1;
        #1 checks++;
        if (o !== O_RST) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", o, O_RST); end
        else $display("ok reset_outputs %b", o);
        @(negedge clk); rst = 0; clear_inputs();
        #1 checks++;
        if ({o, pif.stall_count, pif.flush_count} !== {O_RUN, 32'd0}) begin
            failures++; $display("FAIL reset_release got=%b/%0d/%0d exp=%b/0/0", o, pif.stall_count, pif.flush_count, O_RUN);
        end else $display("ok reset_release");
    endtask

    task automatic test_load_use();
        do_reset();
        hazard_main(6'd5, 6'd5, 6'd0, 1'b1);
        #1 checks++;
        if ({o, pif.stall_count} !== {O_STALL, 16'd0}) begin
            failures++; $display("FAIL load_use_rs got=%b/%0d exp=%b/0", o, pif.stall_count, O_STALL);
        end else $display("ok load_use_rs");
        @(negedge clk); clear_inputs();
        #1 checks++;
        if ({o, pif.stall_count} !== {O_RUN, 16'd1}) begin
            failures++; $display("FAIL load_use_release got=%b/%0d exp=%b/1", o, pif.stall_count, O_RUN);
        end else $display("ok load_use_release");
        @(negedge clk); hazard_main(6'd9, 6'd3, 6'd9, 1'b1);
        #1 checks++;
        if (o !== O_STALL) begin failures++; $display("FAIL load_use_rt got=%b exp=%b", o, O_STALL); end
        else $display("ok load_use_rt");
        @(negedge clk); clear_inputs();
        #1 checks++;
        if ({o, pif.stall_count} !== {O_RUN, 16'd2}) begin
            failures++; $display("FAIL load_use_count got=%b/%0d exp=%b/2", o, pif.stall_count, O_RUN);
        end else $display("ok load_use_count");
    endtask

    task automatic test_no_hazard();
        do_reset();
        hazard_main(6'd0, 6'd0, 6'd0, 1'b1);
        #1 checks++;
        if (o !== O_RUN) begin failures++; $display("FAIL nohaz_rd0 got=%b exp=%b", o, O_RUN); end
        else $display("ok nohaz_rd0");
        @(negedge clk); hazard_main(6'd5, 6'd5, 6'd5, 1'b0);
        #1 checks++;
        if (o !== O_RUN) begin failures++; $display("FAIL nohaz_invalid got=%b exp=%b", o, O_RUN); end
        else $display("ok nohaz_invalid");
        @(negedge clk); hazard_main(6'd5, 6'd5, 6'd5, 1'b1); pif.ex_memToReg = 0;
        #1 checks++;
        if (o !== O_RUN) begin failures++; $display("FAIL nohaz_alu got=%b exp=%b", o, O_RUN); end
        else $display("ok nohaz_alu");
        @(negedge clk); clear_inputs(); pif.wb_BranchZ = 1; pif.wb_N = 1;
        #1 checks++;
        if (o !== O_RUN) begin failures++; $display("FAIL branch_not_taken got=%b exp=%b", o, O_RUN); end
        else $display("ok branch_not_taken");
        @(negedge clk); clear_inputs();
        #1 checks++;
        if ({pif.stall_count, pif.flush_count} !== 32'd0) begin
            failures++; $display("FAIL nohaz_counts got=%0d/%0d exp=0/0", pif.stall_count, pif.flush_count);
        end else $display("ok nohaz_counts");
    endtask

    task automatic test_branch();
        do_reset();
        pif.wb_BranchZ = 1; pif.wb_Z = 1;
        #1 checks++;
        if (o !== O_ALU) begin failures++; $display("FAIL branch_c0 got=%b exp=%b", o, O_ALU); end
        else $display("ok branch_c0");
        // Redirect and hazard presented during FLUSH must be ignored.
        @(negedge clk); clear_inputs(); pif.wb_Jump = 1; hazard_main(6'd5, 6'd5, 6'd0, 1'b1);
        #1 checks++;
        if (o !== O_FLUSH) begin failures++; $display("FAIL branch_c1 got=%b exp=%b", o, O_FLUSH); end
        else $display("ok branch_c1");
        @(negedge clk); clear_inputs();
        #1 checks++;
        if ({o, pif.flush_count, pif.stall_count} !== {O_RUN, 16'd1, 16'd0}) begin
            failures++; $display("FAIL branch_c2 got=%b/%0d/%0d exp=%b/1/0", o, pif.flush_count, pif.stall_count, O_RUN);
        end else $display("ok branch_c2");
        @(negedge clk); pif.wb_BranchN = 1; pif.wb_N = 1;
        #1 checks++;
        if (o !== O_ALU) begin failures++; $display("FAIL branchn got=%b exp=%b", o, O_ALU); end
        else $display("ok branchn");
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_jumpmem_hazard();
        do_reset();
        hazard_main(6'd7, 6'd7, 6'd0, 1'b1); pif.wb_JumpMem = 1;
        #1 checks++;
        if (o !== O_MEM) begin failures++; $display("FAIL jmem_c0 got=%b exp=%b", o, O_MEM); end
        else $display("ok jmem_c0");
        @(negedge clk); clear_inputs();
        @(negedge clk);
        #1 checks++;
        if ({o, pif.stall_count, pif.flush_count} !== {O_RUN, 16'd0, 16'd1}) begin
            failures++; $display("FAIL jmem_after got=%b/%0d/%0d exp=%b/0/1", o, pif.stall_count, pif.flush_count, O_RUN);
        end else $display("ok jmem_after");
    endtask

    task automatic test_stall3();
        do_reset();
        pif3.ex_memToReg = 1; pif3.ex_RegWrt = 1; pif3.ex_rd = 6'd4; pif3.id_rs = 6'd4; pif3.id_valid = 1;
        #1 checks++;
        if (o3 !== O_STALL) begin failures++; $display("FAIL s3_c0 got=%b exp=%b", o3, O_STALL); end
        else $display("ok s3_c0");
        @(negedge clk); clear_inputs();
        #1 checks++;
        if ({o3, pif3.stall_count} !== {O_STALL, 16'd1}) begin
            failures++; $display("FAIL s3_c1 got=%b/%0d exp=%b/1", o3, pif3.stall_count, O_STALL);
        end else $display("ok s3_c1");
        @(negedge clk);
        #1 checks++;
        if (o3 !== O_STALL) begin failures++; $display("FAIL s3_c2 got=%b exp=%b", o3, O_STALL); end
        else $display("ok s3_c2");
        @(negedge clk);
        #1 checks++;
        if ({o3, pif3.stall_count} !== {O_RUN, 16'd1}) begin
            failures++; $display("FAIL s3_c3 got=%b/%0d exp=%b/1", o3, pif3.stall_count, O_RUN);
        end else $display("ok s3_c3");
        // Second run: redirect on the second stall cycle aborts the stall.
        @(negedge clk); pif3.ex_memToReg = 1; pif3.ex_RegWrt = 1; pif3.ex_rd = 6'd4; pif3.id_rt = 6'd4; pif3.id_valid = 1;
        @(negedge clk); clear_inputs(); pif3.wb_Jump = 1;
        #1 checks++;
        if (o3 !== O_ALU) begin failures++; $display("FAIL s3_abort got=%b exp=%b", o3, O_ALU); end
        else $display("ok s3_abort");
        @(negedge clk); clear_inputs();
        #1 checks++;
        if ({o3, pif3.stall_count, pif3.flush_count} !== {O_FLUSH, 16'd2, 16'd1}) begin
            failures++; $display("FAIL s3_flush got=%b/%0d/%0d exp=%b/2/1", o3, pif3.stall_count, pif3.flush_count, O_FLUSH);
        end else $display("ok s3_flush");
        rst = 1;
        #1 checks++;
        if (o3 !== O_RST) begin failures++; $display("FAIL s3_rst got=%b exp=%b", o3, O_RST); end
        else $display("ok s3_rst");
        @(negedge clk); rst = 0;
        #1 checks++;
        if ({o3, pif3.stall_count, pif3.flush_count} !== {O_RUN, 32'd0}) begin
            failures++; $display("FAIL s3_post_rst got=%b/%0d/%0d exp=%b/0/0", o3, pif3.stall_count, pif3.flush_count, O_RUN);
        end else $display("ok s3_post_rst");
    endtask

    task automatic test_saturate();
        do_reset();
        hazard_main(6'd1, 6'd1, 6'd0, 1'b1);
        repeat (65534) @(negedge clk);
        #1 checks++;
        if (pif.stall_count !== 16'hFFFE) begin failures++; $display("FAIL sat_fffe got=%h exp=fffe", pif.stall_count); end
        else $display("ok sat_fffe");
        @(negedge clk);
        #1 checks++;
        if (pif.stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_ffff got=%h exp=ffff", pif.stall_count); end
        else $display("ok sat_ffff");
        repeat (5) @(negedge clk);
        clear_inputs();
        #1 checks++;
        if (pif.stall_count !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", pif.stall_count); end
        else $display("ok sat_hold");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_jumpmem_hazard();
        test_stall3();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 1, meaning bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 Parameter FLUSH_CYCLES, default 2, meaning total cycles the flush outputs stay asserted after a taken redirect (legal 1..7).
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Ports id_rs, id_rt  in  6 each  source register numbers of the instruction in decode.
REQ-006 Port id_valid  in  1  decode stage holds a real instruction.
REQ-007 Ports ex_memToReg, ex_RegWrt  in  1 each  control bits of the instruction in EX.
REQ-008 Port ex_rd  in  6  destination register of the instruction in EX.
REQ-009 Ports wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem, wb_N, wb_Z  in  1 each  EX/WB register outputs.
REQ-010 Ports pc_en, ifid_en  out  1 each  PC and IF/ID register load enables.
REQ-011 Ports ifid_flush, idex_flush, exwb_flush  out  1 each  force the named pipeline register to a bubble (all control bits 0).
REQ-012 Port pc_sel  out  2  next-PC source: 00 sequential, 01 ALU target, 10 memory target.
REQ-013 Ports stall_count, flush_count  out  16 each  saturating event counters.

Function
REQ-014 hazard = id_valid & ex_memToReg & ex_RegWrt & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt).
REQ-015 taken = wb_Jump | wb_JumpMem | (wb_BranchZ & wb_Z) | (wb_BranchN & wb_N).
REQ-016 FSM states: RUN, STALL, FLUSH; 3-bit down-counter cnt.
REQ-017 RUN, no taken, no hazard: pc_en=1, ifid_en=1, all flushes 0, pc_sel=00.
REQ-018 RUN with hazard and no taken: same cycle pc_en=0, ifid_en=0, idex_flush=1; stall_count increments; if LOAD_STALL>1 next state STALL with cnt=LOAD_STALL-1, else stay RUN.
REQ-019 STALL: outputs as REQ-018; cnt decrements each cycle; at cnt==1 next state RUN; stall_count not incremented again.
REQ-020 taken in RUN or STALL (priority over hazard): same cycle pc_sel=10 if wb_JumpMem else 01, pc_en=1, ifid_flush=idex_flush=exwb_flush=1, ifid_en=1; flush_count increments; if FLUSH_CYCLES>1 next state FLUSH with cnt=FLUSH_CYCLES-1, else RUN.
REQ-021 FLUSH: pc_en=1, ifid_en=1, all three flushes 1, pc_sel=00; taken and hazard ignored; cnt decrements; at cnt==1 next state RUN.
REQ-022 taken during STALL aborts the remaining stall cycles.
REQ-023 Counters saturate at 16'hFFFF; no wrap.
REQ-024 All outputs are combinational from state, cnt and inputs; no added latency.

Reset
REQ-025 rst sampled high: next state RUN, cnt=0, stall_count=0, flush_count=0.
REQ-026 While rst is high: pc_en=0, ifid_en=0, all flushes 1, pc_sel=00, regardless of other inputs.
REQ-027 rst asserted mid-STALL or mid-FLUSH abandons the sequence; first cycle after reset behaves per REQ-017.

Structure
REQ-028 Shared package pipe_pkg holds state encoding, pc_sel encodings (PC_SEQ, PC_ALU, PC_MEM) and REG_W=6.
REQ-029 One sub-module sat_cnt16 (enable, synchronous clear, saturating 16-bit) instantiated twice.

Verification
REQ-030 ex_memToReg=1, ex_RegWrt=1, ex_rd=5, id_rs=5, id_valid=1, LOAD_STALL=1 -> one cycle pc_en=0, idex_flush=1; stall_count=1.
REQ-031 Same with ex_rd=0 or id_valid=0 -> no stall; stall_count stays 0.
REQ-032 wb_BranchZ=1, wb_Z=1, FLUSH_CYCLES=2 -> cycle0 pc_sel=01 with all flushes 1, cycle1 flushes 1 and pc_sel=00, cycle2 RUN; flush_count=1.
REQ-033 wb_JumpMem=1 asserted simultaneously with a hazard -> pc_sel=10, no stall, stall_count=0.
REQ-034 LOAD_STALL=3, taken on second stall cycle -> stall aborted, FLUSH entered; rst pulsed mid-FLUSH -> outputs per REQ-026, then RUN, counters 0.
REQ-035 Force 65540 hazards -> stall_count holds 16'hFFFF.
